// File: rtl/mux_pkg.sv
// Shared constants and types for the mux/demux selector bank.
package mux_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef logic [WIDTH_DEFAULT-1:0] bus_word_t;

endpackage : mux_pkg

// File: rtl/dmux_bit.sv
// 1-bit 1:2 demultiplexer; the unselected output is forced low.
module dmux_bit (
    input  logic din,
    input  logic sel,
    output logic a_c,
    output logic b_c
);

    assign a_c = ~sel & din;
    assign b_c = sel & din;

endmodule : dmux_bit

// File: rtl/mux_bit.sv
// 1-bit 2:1 multiplexer in AND-OR gate form so an X on the unselected leg is masked.
module mux_bit (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y_c
);

    assign y_c = (sel & b) | (~sel & a);

endmodule : mux_bit

// File: rtl/mux_bus.sv
// WIDTH-bit 2:1 bus multiplexer built from per-bit mux_bit slices, bit order preserved.
module mux_bus
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y_c
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_bit u_mux_bit (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .y_c (y_c[i])
        );
    end

endmodule : mux_bus

// File: rtl/mux_dmux_bank.sv
// Registered bank of a bit mux, a bit demux and a bus mux with independent selects.
module mux_dmux_bank
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mux_a,
    input  logic             mux_b,
    input  logic             mux_sel,
    input  logic             dmux_in,
    input  logic             dmux_sel,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic             bus_sel,
    output logic             mux_out,
    output logic             dmux_a,
    output logic             dmux_b,
    output logic [WIDTH-1:0] bus_out,
    output logic             valid
);

    logic             mux_out_c;
    logic             dmux_a_c;
    logic             dmux_b_c;
    logic [WIDTH-1:0] bus_out_c;

    mux_bit u_mux_bit (
        .a   (mux_a),
        .b   (mux_b),
        .sel (mux_sel),
        .y_c (mux_out_c)
    );

    dmux_bit u_dmux_bit (
        .din (dmux_in),
        .sel (dmux_sel),
        .a_c (dmux_a_c),
        .b_c (dmux_b_c)
    );

    mux_bus #(
        .WIDTH (WIDTH)
    ) u_mux_bus (
        .a   (bus_a),
        .b   (bus_b),
        .sel (bus_sel),
        .y_c (bus_out_c)
    );

    // Single output stage; reset clears everything at once, en=0 holds all state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_out <= 1'b0;
            dmux_a  <= 1'b0;
            dmux_b  <= 1'b0;
            bus_out <= '0;
            valid   <= 1'b0;
        end else if (en) begin
            mux_out <= mux_out_c;
            dmux_a  <= dmux_a_c;
            dmux_b  <= dmux_b_c;
            bus_out <= bus_out_c;
            valid   <= 1'b1;
        end
    end

endmodule : mux_dmux_bank

// File: tb/tb_mux_dmux_bank.sv
// Directed self-checking bench for mux_dmux_bank.
module tb_mux_dmux_bank;
    import mux_pkg::*;

    logic      clk;
    logic      rst;
    logic      en;
    logic      mux_a, mux_b, mux_sel;
    logic      dmux_in, dmux_sel;
    bus_word_t bus_a, bus_b;
    logic      bus_sel;
    logic      mux_out, dmux_a, dmux_b, valid;
    bus_word_t bus_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed view of every output: {mux_out, dmux_a, dmux_b, valid, bus_out}
    logic [19:0] obs;
    logic [19:0] exp_v;
    assign obs = {mux_out, dmux_a, dmux_b, valid, bus_out};

    mux_dmux_bank #(.WIDTH(WIDTH_DEFAULT)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mux_a    (mux_a),
        .mux_b    (mux_b),
        .mux_sel  (mux_sel),
        .dmux_in  (dmux_in),
        .dmux_sel (dmux_sel),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .bus_sel  (bus_sel),
        .mux_out  (mux_out),
        .dmux_a   (dmux_a),
        .dmux_b   (dmux_b),
        .bus_out  (bus_out),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        mux_a = 1'b1; mux_b = 1'b1; mux_sel = 1'b1;
        dmux_in = 1'b1; dmux_sel = 1'b1;
        bus_a = 16'hFFFF; bus_b = 16'hFFFF; bus_sel = 1'b1;
        step();
        n_checks++;
        if (obs !== 20'h0_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, 20'h0_0000);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL all_ones_capture: got %h expected %h", obs, exp_v);
        end
        // Async assertion between edges must clear outputs before any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 20'h0_0000) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs, 20'h0_0000);
        end
        step();
        step();
        n_checks++;
        if (obs !== 20'h0_0000) begin
            n_fail++;
            $display("FAIL reset_overrides_en: got %h expected %h", obs, 20'h0_0000);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        step();
        n_checks++;
        if (obs !== 20'h0_0000) begin
            n_fail++;
            $display("FAIL no_capture_after_reset_en0: got %h expected %h", obs, 20'h0_0000);
        end
        en = 1'b1;
        step();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL first_capture_after_reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_bus_mux();
        bus_word_t va [4] = '{16'h0000, 16'h0000, 16'hA5A5, 16'hA5A5};
        bus_word_t vb [4] = '{16'h0001, 16'h0001, 16'h5A5A, 16'h5A5A};
        bus_word_t ve [4] = '{16'h0000, 16'h0001, 16'hA5A5, 16'h5A5A};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a = va[i]; bus_b = vb[i]; bus_sel = i[0];
            step();
            n_checks++;
            if (bus_out !== ve[i]) begin
                n_fail++;
                $display("FAIL bus_mux[%0d]: got %h expected %h", i, bus_out, ve[i]);
            end
        end
    endtask

    task automatic test_bit_mux();
        logic e;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mux_a = (i >= 4); mux_b = (i < 4); mux_sel = i[0];
            // First half: a=0,b=1 follows sel; second half: a=1,b=0 inverts it.
            e = (i < 4) ? i[0] : ~i[0];
            step();
            n_checks++;
            if (mux_out !== e) begin
                n_fail++;
                $display("FAIL bit_mux[%0d]: got %b expected %b", i, mux_out, e);
            end
        end
    endtask

    task automatic test_demux();
        logic [1:0] ve [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmux_in = (i < 2); dmux_sel = i[0];
            step();
            n_checks++;
            if ({dmux_a, dmux_b} !== ve[i]) begin
                n_fail++;
                $display("FAIL demux[%0d]: got %b expected %b", i, {dmux_a, dmux_b}, ve[i]);
            end
        end
    endtask

    task automatic test_counter_sweep();
        logic [2:0] c;
        en = 1'b1;
        mux_a = 1'b0; mux_b = 1'b1; bus_a = 16'h0000; bus_b = 16'h0001; dmux_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            mux_sel = c[0]; bus_sel = c[2]; dmux_sel = c[2];
            step();
            exp_v = {c[0], ~c[2], c[2], 1'b1, (c[2] ? 16'h0001 : 16'h0000)};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_x_masking();
        en = 1'b1;
        mux_a = 1'b0; mux_b = 1'bx; mux_sel = 1'b0;
        bus_a = 16'h3C3C; bus_b = 16'hxxxx; bus_sel = 1'b0;
        step();
        n_checks++;
        if ({mux_out, bus_out} !== {1'b0, 16'h3C3C}) begin
            n_fail++;
            $display("FAIL x_masking: got %h expected %h", {mux_out, bus_out}, {1'b0, 16'h3C3C});
        end
    endtask

    task automatic test_enable_hold();
        logic [19:0] held;
        en = 1'b1;
        mux_a = 1'b1; mux_b = 1'b0; mux_sel = 1'b0;
        dmux_in = 1'b1; dmux_sel = 1'b1;
        bus_a = 16'h1234; bus_b = 16'hABCD; bus_sel = 1'b1;
        step();
        held = {1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD};
        n_checks++;
        if (obs !== held) begin
            n_fail++;
            $display("FAIL hold_setup: got %h expected %h", obs, held);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mux_a = i[0]; mux_b = ~i[0]; mux_sel = ~i[0];
            dmux_in = 1'b1; dmux_sel = 1'b0;
            bus_a = 16'h0F0F + 16'(i); bus_b = 16'hF0F0; bus_sel = 1'b0;
            step();
            n_checks++;
            if (obs !== held) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs, held);
            end
        end
        // Last driven: mux_sel=1,b=1 -> 1; dmux sel=0 -> (1,0); bus_a=0x0F11.
        en = 1'b1;
        step();
        exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0F11};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL hold_release: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_bus_mux();
        test_bit_mux();
        test_demux();
        test_counter_sweep();
        test_x_masking();
        test_enable_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_dmux_bank
